// File: rtl/key_loader.sv
// key_loader: serial key loader for a logic-locked netlist.
//
// A load is requested with start (from IDLE or ERROR). KEY_W key bits are
// then shifted in MSB first on sin, qualified by sin_vld. They are followed
// by an 8-bit CRC-8 (poly 0x07, init 0x00, MSB first). If the received CRC
// matches the CRC of the key bits, the key is published and frozen until
// reset. Each mismatch increments a fail counter. When that counter reaches
// MAX_FAIL the block locks out permanently (DEAD) until reset.
//
// Ports:
//   CLK      rising-edge clock
//   RN       synchronous active-low reset
//   start    begin a load (honoured only in IDLE / ERROR)
//   sin      serial key / CRC bit, MSB first
//   sin_vld  qualifies sin
//   key      published key; zero in every state except LOCKED
//   key_ok   key loaded and CRC-verified
//   busy     load in progress (SHIFT, CRC, CHECK)
//   err      last load failed CRC, or lockout reached
module key_loader #(
  parameter int KEY_W    = 64,
  parameter int MAX_FAIL = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [KEY_W-1:0] key,
  output logic             key_ok,
  output logic             busy,
  output logic             err
);

  // One counter serves both the key phase (0..KEY_W-1) and the CRC phase (0..7).
  // KEY_W >= 8 keeps this counter at least 3 bits wide.
  localparam int CNT_W  = $clog2(KEY_W);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CRC, S_CHECK, S_LOCKED, S_ERROR, S_DEAD
  } state_t;

  state_t             state_q,  state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [7:0]         crc_q,    crc_d;
  logic [7:0]         crc_rx_q, crc_rx_d;
  logic [FAIL_W-1:0]  fail_q,   fail_d;
  logic [KEY_W-1:0]   key_q,    key_d;
  logic               key_ok_q, key_ok_d;
  logic               busy_q,   busy_d;
  logic               err_q,    err_d;

  logic [7:0]         crc_next;
  logic [FAIL_W-1:0]  fail_inc;

  // Serial CRC-8 update for one incoming bit.
  assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sin) ? 8'h07 : 8'h00);
  assign fail_inc = fail_q + FAIL_W'(1);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    crc_rx_d = crc_rx_q;
    fail_d   = fail_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d  = S_SHIFT;
          shadow_d = '0;
          cnt_d    = '0;
          crc_d    = '0;
          crc_rx_d = '0;
        end
      end
      S_SHIFT: begin
        if (sin_vld) begin
          shadow_d = {shadow_q[KEY_W-2:0], sin};
          crc_d    = crc_next;
          if (cnt_q == CNT_W'(KEY_W - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CRC: begin
        if (sin_vld) begin
          crc_rx_d = {crc_rx_q[6:0], sin};
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (crc_rx_q == crc_q) begin
          state_d = S_LOCKED;
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc >= FAIL_W'(MAX_FAIL)) ? S_DEAD : S_ERROR;
        end
      end
      default: ; // LOCKED and DEAD are terminal until reset
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q.
  // key is captured from the shadow only on the CHECK->LOCKED edge.
  always_comb begin
    busy_d   = (state_d == S_SHIFT) || (state_d == S_CRC) || (state_d == S_CHECK);
    key_ok_d = (state_d == S_LOCKED);
    err_d    = (state_d == S_ERROR) || (state_d == S_DEAD);
    key_d    = '0;
    if (state_d == S_LOCKED)
      key_d = (state_q == S_CHECK) ? shadow_q : key_q;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      crc_rx_q <= '0;
      fail_q   <= '0;
      key_q    <= '0;
      key_ok_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      crc_rx_q <= crc_rx_d;
      fail_q   <= fail_d;
      key_q    <= key_d;
      key_ok_q <= key_ok_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign key    = key_q;
  assign key_ok = key_ok_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
